// File: rtl/rfsynth_prog_pkg.sv
// Shared constants, state encoding and frequency helpers for the hop synthesizer programmer.
package rfsynth_prog_pkg;

    localparam logic [11:0] FREQ_BASE_TX = 12'd2402;
    localparam logic [11:0] FREQ_BASE_RX = 12'd2400;
    localparam logic [6:0]  CHAN_MAX     = 7'd78;
    localparam logic [9:0]  LOCK_TIMEOUT = 10'd900;
    localparam int          BIT_CYCLES   = 4;
    localparam int          WORD_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        LATCH     = 2'd2,
        WAIT_LOCK = 2'd3
    } state_t;

    // RX uses a 2 MHz low IF, so its LO sits 2 MHz below the TX carrier.
    function automatic logic [11:0] calc_freq(input logic tx, input logic [6:0] ch);
        return (tx ? FREQ_BASE_TX : FREQ_BASE_RX) + {5'd0, ch};
    endfunction

    function automatic logic [15:0] serial_word(input logic tx, input logic [11:0] freq);
        return {tx, 3'b000, freq};
    endfunction

endpackage

// File: rtl/synth_shift.sv
// 16-bit parallel-load serializer: MSB first, each bit held BIT_CYCLES clocks,
// sclk low for the first half of the bit period and high for the second half.
module synth_shift
    import rfsynth_prog_pkg::*;
(
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        start,
    input  logic [15:0] word,
    output logic        sclk,
    output logic        sdata,
    output logic        done
);

    localparam logic [1:0] PHASE_LAST = 2'(BIT_CYCLES - 1);
    localparam logic [1:0] PHASE_HIGH = 2'(BIT_CYCLES / 2);
    localparam logic [3:0] BIT_LAST   = 4'(WORD_BITS - 1);

    logic        active_reg, active_next;
    logic [15:0] sr_reg, sr_next;
    logic [1:0]  phase_reg, phase_next;
    logic [3:0]  bit_reg, bit_next;
    logic        sclk_reg, sclk_next;
    logic        sdata_reg, sdata_next;

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            active_reg <= 1'b0;
            sr_reg     <= '0;
            phase_reg  <= '0;
            bit_reg    <= '0;
            sclk_reg   <= 1'b0;
            sdata_reg  <= 1'b0;
        end else begin
            active_reg <= active_next;
            sr_reg     <= sr_next;
            phase_reg  <= phase_next;
            bit_reg    <= bit_next;
            sclk_reg   <= sclk_next;
            sdata_reg  <= sdata_next;
        end
    end

    always_comb begin
        active_next = active_reg;
        sr_next     = sr_reg;
        phase_next  = phase_reg;
        bit_next    = bit_reg;
        sclk_next   = sclk_reg;
        sdata_next  = sdata_reg;
        if (start) begin
            // A load while already shifting simply restarts with the new word.
            active_next = 1'b1;
            sr_next     = word;
            phase_next  = '0;
            bit_next    = '0;
            sclk_next   = 1'b0;
            sdata_next  = word[15];
        end else if (active_reg) begin
            if (phase_reg == PHASE_LAST) begin
                phase_next = '0;
                sclk_next  = 1'b0;
                if (bit_reg == BIT_LAST) begin
                    active_next = 1'b0;
                    sdata_next  = 1'b0;
                end else begin
                    bit_next   = bit_reg + 4'd1;
                    sr_next    = {sr_reg[14:0], 1'b0};
                    sdata_next = sr_reg[14];
                end
            end else begin
                phase_next = phase_reg + 2'd1;
                sclk_next  = ((phase_reg + 2'd1) >= PHASE_HIGH);
            end
        end
    end

    assign sclk  = sclk_reg;
    assign sdata = sdata_reg;
    // High during the final cycle of the last bit so the owner can move on without a gap.
    assign done  = active_reg && (phase_reg == PHASE_LAST) && (bit_reg == BIT_LAST);

endmodule

// File: rtl/rfsynth_prog.sv
// Hop synthesizer programmer: computes the LO word, shifts it to the radio,
// pulses the latch enable and then waits for PLL lock or a timeout.
module rfsynth_prog
    import rfsynth_prog_pkg::*;
(
    input  logic        clk_6M,
    input  logic        rstz,
    input  logic        fkset_p,
    input  logic [6:0]  chan,
    input  logic        txrx,
    input  logic        pll_lock,
    output logic        sclk,
    output logic        sdata,
    output logic        sle,
    output logic        synth_busy,
    output logic [11:0] freq_word,
    output logic        synth_done_p,
    output logic        lock_err_p,
    output logic        chan_err_p,
    output logic        overrun_p
);

    state_t      state_reg, state_next;
    logic [11:0] freq_reg, freq_next;
    logic        lat_reg, lat_next;
    logic [9:0]  tmo_reg, tmo_next;
    logic        lock_s1_reg, lock_s2_reg;
    logic        sle_reg, sle_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        lerr_reg, lerr_next;
    logic        cerr_reg, cerr_next;
    logic        ovr_reg, ovr_next;

    logic        accept;
    logic        shift_start;
    logic        shift_done;
    logic [11:0] freq_calc;

    assign freq_calc = calc_freq(txrx, chan);
    assign accept    = fkset_p && (chan <= CHAN_MAX);

    synth_shift u_shift (
        .clk_6M (clk_6M),
        .rstz   (rstz),
        .start  (shift_start),
        .word   (serial_word(txrx, freq_calc)),
        .sclk   (sclk),
        .sdata  (sdata),
        .done   (shift_done)
    );

    always_ff @(posedge clk_6M or negedge rstz) begin
        if (!rstz) begin
            state_reg   <= IDLE;
            freq_reg    <= '0;
            lat_reg     <= 1'b0;
            tmo_reg     <= '0;
            lock_s1_reg <= 1'b0;
            lock_s2_reg <= 1'b0;
            sle_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            lerr_reg    <= 1'b0;
            cerr_reg    <= 1'b0;
            ovr_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            freq_reg    <= freq_next;
            lat_reg     <= lat_next;
            tmo_reg     <= tmo_next;
            lock_s1_reg <= pll_lock;
            lock_s2_reg <= lock_s1_reg;
            sle_reg     <= sle_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            lerr_reg    <= lerr_next;
            cerr_reg    <= cerr_next;
            ovr_reg     <= ovr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        freq_next   = freq_reg;
        lat_next    = lat_reg;
        tmo_next    = tmo_reg;
        done_next   = 1'b0;
        lerr_next   = 1'b0;
        cerr_next   = 1'b0;
        ovr_next    = 1'b0;
        shift_start = 1'b0;

        if (accept) begin
            // A restart wins over any completion of the aborted sequence this cycle.
            shift_start = 1'b1;
            freq_next   = freq_calc;
            state_next  = SHIFT;
            ovr_next    = (state_reg != IDLE);
        end else begin
            cerr_next = fkset_p;
            case (state_reg)
                SHIFT: begin
                    if (shift_done) begin
                        state_next = LATCH;
                        lat_next   = 1'b0;
                    end
                end
                LATCH: begin
                    if (lat_reg) begin
                        state_next = WAIT_LOCK;
                        tmo_next   = '0;
                    end else begin
                        lat_next = 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s2_reg) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if (tmo_reg == LOCK_TIMEOUT - 10'd1) begin
                        lerr_next  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        tmo_next = tmo_reg + 10'd1;
                    end
                end
                default: ;
            endcase
        end

        sle_next  = (state_next == LATCH);
        busy_next = (state_next != IDLE);
    end

    assign sle          = sle_reg;
    assign synth_busy   = busy_reg;
    assign freq_word    = freq_reg;
    assign synth_done_p = done_reg;
    assign lock_err_p   = lerr_reg;
    assign chan_err_p   = cerr_reg;
    assign overrun_p    = ovr_reg;

endmodule

// File: tb/tb_rfsynth_prog.sv
// Scoreboard bench for rfsynth_prog: expected serial words are queued when a hop is
// requested and checked when the radio latch enable rises.
module tb_rfsynth_prog;

    localparam int HIST = 1100;

    logic        clk_6M;
    logic        rstz;
    logic        fkset_p;
    logic [6:0]  chan;
    logic        txrx;
    logic        pll_lock;
    logic        sclk;
    logic        sdata;
    logic        sle;
    logic        synth_busy;
    logic [11:0] freq_word;
    logic        synth_done_p;
    logic        lock_err_p;
    logic        chan_err_p;
    logic        overrun_p;

    rfsynth_prog dut (
        .clk_6M       (clk_6M),
        .rstz         (rstz),
        .fkset_p      (fkset_p),
        .chan         (chan),
        .txrx         (txrx),
        .pll_lock     (pll_lock),
        .sclk         (sclk),
        .sdata        (sdata),
        .sle          (sle),
        .synth_busy   (synth_busy),
        .freq_word    (freq_word),
        .synth_done_p (synth_done_p),
        .lock_err_p   (lock_err_p),
        .chan_err_p   (chan_err_p),
        .overrun_p    (overrun_p)
    );

    initial clk_6M = 1'b0;
    always #83 clk_6M = ~clk_6M;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    int          cyc;
    logic [15:0] cap_word;
    int          cap_bits;
    logic        prev_sclk, prev_sle;
    int          sle_first, sle_last, sle_count;
    int          done_cnt, done_cyc, lerr_cnt, lerr_cyc;
    int          cerr_cnt, cerr_cyc, ovr_cnt, ovr_cyc;
    int          busy_seen;
    logic        sclk_h[HIST];
    logic        sdata_h[HIST];
    logic        busy_h[HIST];

    task automatic clear_obs();
        sle_first = -1; sle_last = -1; sle_count = 0;
        done_cnt = 0; done_cyc = -1; lerr_cnt = 0; lerr_cyc = -1;
        cerr_cnt = 0; cerr_cyc = -1; ovr_cnt = 0; ovr_cyc = -1;
        busy_seen = 0;
    endtask

    // One clock: advance, then sample mid-cycle on the falling edge.
    task automatic step();
        logic [15:0] exp_word;
        @(posedge clk_6M);
        cyc++;
        @(negedge clk_6M);
        if (cyc < HIST) begin
            sclk_h[cyc]  = sclk;
            sdata_h[cyc] = sdata;
            busy_h[cyc]  = synth_busy;
        end
        if (synth_busy) busy_seen++;
        if (sclk && !prev_sclk) begin
            cap_word = {cap_word[14:0], sdata};
            cap_bits++;
        end
        if (sle && !prev_sle) begin
            sle_first = cyc;
            sle_count++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL latch_word: latch with no pending hop, got %h", cap_word);
            end else begin
                exp_word = exp_q.pop_front();
                $display("[TB] latch at cycle %0d: word %h (%0d bits), expected %h", cyc, cap_word, cap_bits, exp_word);
                if (cap_word !== exp_word || cap_bits != 16) begin
                    fails++;
                    $display("FAIL latch_word: got %h/%0d bits, expected %h/16", cap_word, cap_bits, exp_word);
                end
            end
        end
        if (sle) sle_last = cyc;
        if (synth_done_p) begin done_cnt++; done_cyc = cyc; end
        if (lock_err_p)   begin lerr_cnt++; lerr_cyc = cyc; end
        if (chan_err_p)   begin cerr_cnt++; cerr_cyc = cyc; end
        if (overrun_p)    begin ovr_cnt++;  ovr_cyc = cyc;  end
        prev_sclk = sclk;
        prev_sle  = sle;
    endtask

    // Present fkset_p for one cycle; that cycle is cycle 0 of the new sequence.
    task automatic issue(input logic tx, input logic [6:0] ch);
        txrx = tx;
        chan = ch;
        fkset_p = 1'b1;
        cyc = 0;
        cap_word = '0;
        cap_bits = 0;
        step();
        fkset_p = 1'b0;
    endtask

    task automatic run_to(input int upto, input int lock_at);
        while (cyc < upto) begin
            step();
            if (lock_at >= 0 && cyc >= lock_at) pll_lock = 1'b1;
        end
    endtask

    task automatic settle();
        pll_lock = 1'b0;
        cyc = 0;
        run_to(6, -1);
    endtask

    task automatic test_reset();
        rstz = 1'b0;
        @(negedge clk_6M);
        @(negedge clk_6M);
        tests++;
        if ({sclk, sdata, sle, synth_busy, synth_done_p, lock_err_p, chan_err_p, overrun_p} !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs: got %b, expected 00000000",
                     {sclk, sdata, sle, synth_busy, synth_done_p, lock_err_p, chan_err_p, overrun_p});
        end
        tests++;
        if (freq_word !== 12'd0) begin
            fails++;
            $display("FAIL reset_freq: got %0d, expected 0", freq_word);
        end
        rstz = 1'b1;
        settle();
    endtask

    task automatic test_tx_chan0();
        clear_obs();
        exp_q.push_back(16'h8962);
        issue(1'b1, 7'd0);
        run_to(120, 100);
        tests++;
        if (busy_h[1] !== 1'b1) begin fails++; $display("FAIL tx_busy_c1: got %b, expected 1", busy_h[1]); end
        tests++;
        if ({sclk_h[1], sclk_h[2], sclk_h[3], sclk_h[4], sclk_h[5]} !== 5'b00110) begin
            fails++;
            $display("FAIL tx_sclk_phase: got %b, expected 00110",
                     {sclk_h[1], sclk_h[2], sclk_h[3], sclk_h[4], sclk_h[5]});
        end
        tests++;
        if ({sdata_h[1], sdata_h[4], sdata_h[5], sdata_h[64], sdata_h[65]} !== 5'b11000) begin
            fails++;
            $display("FAIL tx_sdata: got %b, expected 11000",
                     {sdata_h[1], sdata_h[4], sdata_h[5], sdata_h[64], sdata_h[65]});
        end
        tests++;
        if (sle_first != 65 || sle_last != 66 || sle_count != 1) begin
            fails++;
            $display("FAIL tx_sle_window: got %0d..%0d x%0d, expected 65..66 x1", sle_first, sle_last, sle_count);
        end
        tests++;
        if (sclk_h[65] !== 1'b0 || sclk_h[67] !== 1'b0) begin
            fails++;
            $display("FAIL tx_sclk_quiet: got %b%b, expected 00", sclk_h[65], sclk_h[67]);
        end
        tests++;
        if (done_cnt != 1 || done_cyc < 101 || done_cyc > 104 || lerr_cnt != 0) begin
            fails++;
            $display("FAIL tx_done: got %0d pulses at %0d (lerr %0d), expected 1 at 101..104", done_cnt, done_cyc, lerr_cnt);
        end
        tests++;
        if (done_cyc > 0 && busy_h[done_cyc] !== 1'b0) begin
            fails++;
            $display("FAIL tx_busy_fall: got %b at done, expected 0", busy_h[done_cyc]);
        end
        tests++;
        if (freq_word !== 12'd2402) begin fails++; $display("FAIL tx_freq: got %0d, expected 2402", freq_word); end
        settle();
    endtask

    task automatic test_rx_chan78();
        clear_obs();
        exp_q.push_back(16'h09AE);
        issue(1'b0, 7'd78);
        run_to(120, 100);
        tests++;
        if (freq_word !== 12'd2478) begin fails++; $display("FAIL rx_freq: got %0d, expected 2478", freq_word); end
        tests++;
        if (done_cnt != 1 || sle_count != 1) begin
            fails++;
            $display("FAIL rx_done: got %0d done / %0d latches, expected 1/1", done_cnt, sle_count);
        end
        settle();
    endtask

    task automatic test_chan_err();
        clear_obs();
        issue(1'b1, 7'd79);
        run_to(80, -1);
        tests++;
        if (cerr_cnt != 1 || cerr_cyc != 1) begin
            fails++;
            $display("FAIL chan_err_pulse: got %0d at %0d, expected 1 at 1", cerr_cnt, cerr_cyc);
        end
        tests++;
        if (busy_seen != 0 || cap_bits != 0 || sle_count != 0) begin
            fails++;
            $display("FAIL chan_err_quiet: got busy %0d sclk %0d sle %0d, expected 0 0 0", busy_seen, cap_bits, sle_count);
        end
        tests++;
        if (freq_word !== 12'd2478) begin fails++; $display("FAIL chan_err_freq: got %0d, expected 2478", freq_word); end
        settle();
    endtask

    task automatic test_lock_timeout();
        clear_obs();
        exp_q.push_back(16'h896C);
        issue(1'b1, 7'd10);
        run_to(975, -1);
        tests++;
        if (lerr_cnt != 1 || lerr_cyc != 967 || done_cnt != 0) begin
            fails++;
            $display("FAIL timeout_pulse: got %0d at %0d (done %0d), expected 1 at 967", lerr_cnt, lerr_cyc, done_cnt);
        end
        tests++;
        if (busy_h[966] !== 1'b1 || busy_h[967] !== 1'b0) begin
            fails++;
            $display("FAIL timeout_busy: got %b%b at 966/967, expected 10", busy_h[966], busy_h[967]);
        end
        settle();
    endtask

    task automatic test_back_to_back();
        clear_obs();
        exp_q.push_back(16'h8962);
        issue(1'b1, 7'd0);
        run_to(30, -1);
        exp_q.delete();
        exp_q.push_back(16'h8967);
        issue(1'b1, 7'd5);
        run_to(110, 100);
        tests++;
        if (ovr_cnt != 1 || ovr_cyc != 1) begin
            fails++;
            $display("FAIL overrun_pulse: got %0d at %0d, expected 1 at 1", ovr_cnt, ovr_cyc);
        end
        tests++;
        if (done_cnt != 1 || sle_count != 1 || sle_first != 65) begin
            fails++;
            $display("FAIL overrun_single: got %0d done %0d latches at %0d, expected 1 1 65", done_cnt, sle_count, sle_first);
        end
        tests++;
        if (freq_word !== 12'd2407) begin fails++; $display("FAIL overrun_freq: got %0d, expected 2407", freq_word); end
        settle();
    endtask

    task automatic test_reset_mid();
        clear_obs();
        exp_q.push_back(16'h8962);
        issue(1'b1, 7'd0);
        run_to(40, -1);
        rstz = 1'b0;
        #1;
        tests++;
        if ({sclk, sdata, sle, synth_busy} !== 4'b0000 || freq_word !== 12'd0) begin
            fails++;
            $display("FAIL reset_mid: got %b freq %0d, expected 0000 freq 0", {sclk, sdata, sle, synth_busy}, freq_word);
        end
        exp_q.delete();
        cyc = 0;
        run_to(3, -1);
        rstz = 1'b1;
        run_to(10, -1);
        tests++;
        if (done_cnt + lerr_cnt + cerr_cnt + ovr_cnt != 0 || sle_count != 0) begin
            fails++;
            $display("FAIL reset_mid_pulses: got %0d pulses %0d latches, expected 0 0",
                     done_cnt + lerr_cnt + cerr_cnt + ovr_cnt, sle_count);
        end
        clear_obs();
        exp_q.push_back(16'h0963);
        issue(1'b0, 7'd3);
        run_to(120, 100);
        tests++;
        if (done_cnt != 1 || sle_count != 1 || freq_word !== 12'd2403) begin
            fails++;
            $display("FAIL reset_recover: got %0d done %0d latches freq %0d, expected 1 1 2403", done_cnt, sle_count, freq_word);
        end
        settle();
    endtask

    initial begin
        rstz = 1'b0;
        fkset_p = 1'b0;
        chan = '0;
        txrx = 1'b0;
        pll_lock = 1'b0;
        cyc = 0;
        cap_word = '0;
        cap_bits = 0;
        prev_sclk = 1'b0;
        prev_sle = 1'b0;
        clear_obs();
        test_reset();
        test_tx_chan0();
        test_rx_chan78();
        test_chan_err();
        test_lock_timeout();
        test_back_to_back();
        test_reset_mid();
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/rfsynth_prog.md
RFSYNTH_PROG -- requirements
Module: rfsynth_prog

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk_6M (6 MHz) and rstz.
REQ-002 clk_6M  in  1  system clock, all state on rising edge.
REQ-003 rstz  in  1  asynchronous active-low reset.
REQ-004 fkset_p  in  1  one-cycle request: program the synthesizer for the next hop (PLL setup window start).
REQ-005 chan  in  7  hop channel index from the hop kernel, legal range 0..78, sampled only with fkset_p.
REQ-006 txrx  in  1  1 = TX frequency, 0 = RX frequency, sampled only with fkset_p.
REQ-007 pll_lock  in  1  radio PLL lock indicator, asynchronous to clk_6M.
REQ-008 sclk  out  1  serial clock to the radio.
REQ-009 sdata  out  1  serial data to the radio, MSB first.
REQ-010 sle  out  1  radio latch enable.
REQ-011 synth_busy  out  1  high from the cycle after an accepted fkset_p until done or error.
REQ-012 freq_word  out  12  last programmed LO frequency in MHz.
REQ-013 synth_done_p  out  1  one-cycle pulse: PLL locked after programming.
REQ-014 lock_err_p  out  1  one-cycle pulse: lock timeout.
REQ-015 chan_err_p  out  1  one-cycle pulse: fkset_p with chan > 78.
REQ-016 overrun_p  out  1  one-cycle pulse: fkset_p accepted while synth_busy was high.

Function
REQ-017 Frequency: TX freq_word = 2402 + chan; RX freq_word = 2400 + chan (2 MHz low IF); 12-bit unsigned, no wrap possible for legal chan.
REQ-018 Serial word: 16 bits = {txrx, 3'b000, freq_word}, shifted MSB first.
REQ-019 States: IDLE, SHIFT, LATCH, WAIT_LOCK.
REQ-020 IDLE + fkset_p + legal chan (cycle 0): latch txrx and freq_word, enter SHIFT at cycle 1.
REQ-021 fkset_p with chan > 78: chan_err_p at cycle 1, freq_word unchanged, no programming, state unchanged.
REQ-022 SHIFT: bit k (k = 0 is MSB) held on sdata for cycles 4k+1..4k+4; sclk low in the first two cycles and high in the last two of each bit period; 16 bits occupy cycles 1..64.
REQ-023 LATCH: sle high for cycles 65..66; sclk low and sdata 0 during LATCH.
REQ-024 WAIT_LOCK starts at cycle 67; pll_lock passes through a 2-flop synchronizer; the first synchronized high in WAIT_LOCK gives synth_done_p in the next cycle and a return to IDLE.
REQ-025 Lock timeout: 10-bit counter cleared on entry to WAIT_LOCK; with no synchronized lock after 900 cycles (150 us), lock_err_p fires at cycle 967 and the block returns to IDLE.
REQ-026 A legal fkset_p in any non-IDLE state restarts at SHIFT with new values, fires overrun_p, and suppresses the done/error pulse of the aborted sequence.
REQ-027 synth_busy is low in IDLE and high in SHIFT, LATCH and WAIT_LOCK.
REQ-028 sclk, sdata and sle are all low in IDLE and WAIT_LOCK.
REQ-029 All outputs are registered.

Reset
REQ-030 Reset values: state IDLE, all outputs 0, freq_word 0, synchronizer flops 0, timeout counter 0.
REQ-031 Reset asserted mid-sequence stops the sequence at once (sle, sclk, sdata low) with no pulse output.

Structure
REQ-032 Shared package: FREQ_BASE_TX = 2402, FREQ_BASE_RX = 2400, CHAN_MAX = 78, LOCK_TIMEOUT = 900, BIT_CYCLES = 4, state encoding.
REQ-033 One sub-module, synth_shift: 16-bit parallel-load serializer producing sclk and sdata, with start input and done output.

Verification
REQ-034 TX, chan 0, lock rises at cycle 100: serial word 0x8962; sle high cycles 65..66; synth_done_p a few cycles after 100; freq_word 2402.
REQ-035 RX, chan 78: serial word 0x09AE; freq_word 2478.
REQ-036 chan 79: chan_err_p at cycle 1; no sclk or sle activity; synth_busy stays 0.
REQ-037 pll_lock held 0: lock_err_p exactly at cycle 967; synth_busy falls the same cycle.
REQ-038 Second fkset_p at cycle 30 with chan 5 TX: overrun_p, new word 0x8967 restarts, only one synth_done_p.
REQ-039 rstz asserted at cycle 40: outputs 0 immediately; after release a new fkset_p programs normally.
